spw_rx_nchar_writer: RTL and testbench

- Upstream feeder of the SpaceWire receive FIFO. Takes N-chars decoded by the receiver (data, EOP, EEP) and writes them into the FIFO using its one-cycle-strobe, 3-cycle write protocol.
- Enforces receive-side flow-control credit: 8 N-chars per FCT sent, ECSS-E-ST-50-12C. Flags credit errors and absorbs receiver bursts in a 2-entry holding queue.

---
 rtl/spw_rx_nchar_writer_if.sv | 30 +++
 rtl/spw_rx_nchar_writer.sv | 136 +++++++++++++
 tb/tb_spw_rx_nchar_writer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spw_rx_nchar_writer_if.sv
// Receiver-to-FIFO bundle for the SpaceWire RX N-char writer.
// The slave side is the writer; the master side is the receiver/FIFO environment.
interface spw_rx_nchar_writer_if #(
   parameter int DWIDTH = 9
);
   logic              rx_valid;
   logic [DWIDTH-1:0] rx_nchar;
   logic              fct_sent;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [DWIDTH-1:0] fifo_data;

   modport master (
      output rx_valid,
      output rx_nchar,
      output fct_sent,
      output fifo_full,
      input  fifo_wr_en,
      input  fifo_data
   );

   modport slave (
      input  rx_valid,
      input  rx_nchar,
      input  fct_sent,
      input  fifo_full,
      output fifo_wr_en,
      output fifo_data
   );
endinterface

// File: rtl/spw_rx_nchar_writer.sv
// SpaceWire RX N-char writer: credit accounting, 2-entry holding queue and a
// strobe/gap/gap write sequencer feeding the receive FIFO.
module spw_rx_nchar_writer #(
   parameter int DWIDTH      = 9,
   parameter int CWIDTH      = 6,
   parameter int CREDIT_STEP = 8,
   parameter int CREDIT_MAX  = 56
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                link_run,
   spw_rx_nchar_writer_if.slave bus,
   output logic [CWIDTH-1:0]   credit,
   output logic                credit_error,
   output logic                queue_overflow,
   output logic [1:0]          queue_level
);

   localparam int CW = CWIDTH + 1;
   localparam logic [CWIDTH:0] STEP_W = CW'(CREDIT_STEP);
   localparam logic [CWIDTH:0] MAX_W  = CW'(CREDIT_MAX);
   localparam logic [CWIDTH:0] ONE_W  = CW'(1);

   typedef enum logic [1:0] {IDLE, STROBE, GAP1, GAP2} state_t;

   state_t              state_q, state_d;
   logic [DWIDTH-1:0]   q0_q, q0_d;
   logic [DWIDTH-1:0]   q1_q, q1_d;
   logic [1:0]          level_q, level_d;
   logic [CWIDTH-1:0]   credit_q, credit_d;
   logic                cerr_q, cerr_d;
   logic                ovf_q, ovf_d;
   logic                wr_en_q, wr_en_d;
   logic [DWIDTH-1:0]   data_q, data_d;

   logic                accept;
   logic                pop;
   logic                push;
   logic [1:0]          level_after_pop;
   logic [CWIDTH:0]     credit_sum;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         q0_q     <= '0;
         q1_q     <= '0;
         level_q  <= '0;
         credit_q <= '0;
         cerr_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_en_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         q0_q     <= q0_d;
         q1_q     <= q1_d;
         level_q  <= level_d;
         credit_q <= credit_d;
         cerr_q   <= cerr_d;
         ovf_q    <= ovf_d;
         wr_en_q  <= wr_en_d;
         data_q   <= data_d;
      end
   end

   // The head leaves the queue on the GAP1 cycle, so a strobe always carries a stable head.
   always_comb begin
      state_d         = state_q;
      q0_d            = q0_q;
      q1_d            = q1_q;
      level_d         = level_q;
      credit_d        = credit_q;
      cerr_d          = cerr_q;
      ovf_d           = ovf_q;
      wr_en_d         = 1'b0;
      data_d          = data_q;
      accept          = 1'b0;
      pop             = 1'b0;
      push            = 1'b0;
      level_after_pop = level_q;
      credit_sum      = {1'b0, credit_q};

      case (state_q)
         IDLE:    if (level_q != 2'd0 && !bus.fifo_full) state_d = STROBE;
         STROBE:  state_d = GAP1;
         GAP1:    state_d = GAP2;
         GAP2:    state_d = (level_q != 2'd0 && !bus.fifo_full) ? STROBE : IDLE;
         default: state_d = IDLE;
      endcase

      pop             = (state_q == GAP1);
      level_after_pop = level_q - (pop ? 2'd1 : 2'd0);
      if (pop) q0_d = q1_q;

      // A char that finds no credit is dropped outright; one that finds the queue full still spent credit.
      accept = bus.rx_valid && (credit_q != '0);
      if (bus.rx_valid && credit_q == '0) cerr_d = 1'b1;
      if (accept) begin
         if (level_after_pop < 2'd2) push = 1'b1;
         else                        ovf_d = 1'b1;
      end
      if (push) begin
         if (level_after_pop == 2'd0) q0_d = bus.rx_nchar;
         else                         q1_d = bus.rx_nchar;
      end
      level_d = level_after_pop + (push ? 2'd1 : 2'd0);

      if (bus.fct_sent) credit_sum = credit_sum + STEP_W;
      if (accept)       credit_sum = credit_sum - ONE_W;
      if (credit_sum > MAX_W) credit_sum = MAX_W;
      credit_d = credit_sum[CWIDTH-1:0];

      if (state_d == STROBE) begin
         wr_en_d = 1'b1;
         data_d  = q0_q;
      end

      if (!link_run) begin
         state_d  = IDLE;
         level_d  = 2'd0;
         credit_d = '0;
         cerr_d   = 1'b0;
         ovf_d    = 1'b0;
         wr_en_d  = 1'b0;
         data_d   = data_q;
      end
   end

   assign bus.fifo_wr_en = wr_en_q;
   assign bus.fifo_data  = data_q;
   assign credit         = credit_q;
   assign credit_error   = cerr_q;
   assign queue_overflow = ovf_q;
   assign queue_level    = level_q;

endmodule

// File: tb/tb_spw_rx_nchar_writer.sv
// Self-checking bench for spw_rx_nchar_writer: directed plan plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_spw_rx_nchar_writer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       link_run = 1'b0;
   logic [5:0] credit;
   logic       credit_error;
   logic       queue_overflow;
   logic [1:0] queue_level;

   spw_rx_nchar_writer_if #(.DWIDTH(9)) bus();

   spw_rx_nchar_writer #(
      .DWIDTH(9), .CWIDTH(6), .CREDIT_STEP(8), .CREDIT_MAX(56)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .link_run       (link_run),
      .bus            (bus),
      .credit         (credit),
      .credit_error   (credit_error),
      .queue_overflow (queue_overflow),
      .queue_level    (queue_level)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int last_strobe = -100;
   int wr_count = 0;

   logic [8:0] m_q[$];
   int         m_credit = 0;
   bit         m_cerr = 0;
   bit         m_ovf = 0;
   bit         m_wr = 0;
   logic [8:0] m_data = '0;
   int         m_age = 100;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cycle);
      end
   endtask

   // Reference: a strobe may follow two cycles after the previous one; its char leaves the queue one cycle later.
   task automatic modelStep();
      bit strobe_now;
      bit accepted;
      if (!reset) begin
         m_q.delete();
         m_credit = 0; m_cerr = 0; m_ovf = 0; m_wr = 0; m_data = '0; m_age = 100;
      end else if (!link_run) begin
         m_q.delete();
         m_credit = 0; m_cerr = 0; m_ovf = 0; m_wr = 0; m_age = 100;
      end else begin
         strobe_now = (m_q.size() > 0) && !bus.fifo_full && (m_age >= 2);
         if (strobe_now) m_data = m_q[0];
         if (m_age == 1 && m_q.size() > 0) void'(m_q.pop_front());
         accepted = bus.rx_valid && (m_credit > 0);
         if (bus.rx_valid && m_credit == 0) m_cerr = 1;
         if (accepted) begin
            if (m_q.size() < 2) m_q.push_back(bus.rx_nchar);
            else                m_ovf = 1;
         end
         m_credit = m_credit + (bus.fct_sent ? 8 : 0) - (accepted ? 1 : 0);
         if (m_credit > 56) m_credit = 56;
         m_wr  = strobe_now;
         m_age = strobe_now ? 0 : ((m_age < 100) ? m_age + 1 : 100);
      end
   endtask

   task automatic compareStep();
      cycle++;
      checkOutput("credit", 32'(credit), 32'(m_credit));
      checkOutput("credit_error", 32'(credit_error), 32'(m_cerr));
      checkOutput("queue_overflow", 32'(queue_overflow), 32'(m_ovf));
      checkOutput("queue_level", 32'(queue_level), 32'(m_q.size()));
      checkOutput("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(m_wr));
      if (m_wr) checkOutput("fifo_data", 32'(bus.fifo_data), 32'(m_data));
      if (bus.fifo_wr_en) begin
         checkOutput("strobe_spacing_ok", 32'(cycle - last_strobe >= 3), 32'd1);
         last_strobe = cycle;
         wr_count++;
      end
   endtask

   initial forever begin
      @(posedge clock);
      modelStep();
   end

   initial forever begin
      @(negedge clock);
      compareStep();
   end

   task automatic applyStimulus(input bit rv, input logic [8:0] nc, input bit fct, input bit full, input bit run);
      bus.rx_valid  = rv;
      bus.rx_nchar  = nc;
      bus.fct_sent  = fct;
      bus.fifo_full = full;
      link_run      = run;
      @(posedge clock);
      #1;
      bus.rx_valid = 1'b0;
      bus.fct_sent = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   int base;

   initial begin
      bus.rx_valid  = 1'b0;
      bus.rx_nchar  = '0;
      bus.fct_sent  = 1'b0;
      bus.fifo_full = 1'b0;

      repeat (2) @(negedge clock);
      checkOutput("reset_credit", 32'(credit), 32'd0);
      checkOutput("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      checkOutput("reset_level", 32'(queue_level), 32'd0);
      checkOutput("reset_data", 32'(bus.fifo_data), 32'd0);
      reset = 1'b1;

      // Credit ceiling
      repeat (7) applyStimulus(0, '0, 1, 0, 1);
      @(negedge clock);
      checkOutput("credit_after_7_fct", 32'(credit), 32'd56);
      applyStimulus(0, '0, 1, 0, 1);
      @(negedge clock);
      checkOutput("credit_saturated", 32'(credit), 32'd56);

      // Eight spaced data chars on one FCT
      applyStimulus(0, '0, 0, 0, 0);
      applyStimulus(0, '0, 1, 0, 1);
      @(negedge clock);
      checkOutput("credit_one_fct", 32'(credit), 32'd8);
      base = wr_count;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 9'(9'h010 + i), 0, 0, 1);
         idleCycles(3);
      end
      idleCycles(6);
      @(negedge clock);
      checkOutput("eight_writes", 32'(wr_count - base), 32'd8);
      checkOutput("credit_spent", 32'(credit), 32'd0);
      checkOutput("last_data", 32'(bus.fifo_data), 32'h017);
      checkOutput("no_overflow", 32'(queue_overflow), 32'd0);

      // Char with no credit
      base = wr_count;
      applyStimulus(1, 9'h0AA, 0, 0, 1);
      @(negedge clock);
      checkOutput("credit_error_set", 32'(credit_error), 32'd1);
      idleCycles(5);
      @(negedge clock);
      checkOutput("no_write_on_error", 32'(wr_count - base), 32'd0);
      applyStimulus(0, '0, 0, 0, 0);
      @(negedge clock);
      checkOutput("credit_error_cleared", 32'(credit_error), 32'd0);

      // Queue fill while FIFO full
      applyStimulus(0, '0, 1, 1, 1);
      base = wr_count;
      applyStimulus(1, 9'h031, 0, 1, 1);
      applyStimulus(1, 9'h032, 0, 1, 1);
      applyStimulus(1, 9'h033, 0, 1, 1);
      @(negedge clock);
      checkOutput("held_level", 32'(queue_level), 32'd2);
      checkOutput("overflow_set", 32'(queue_overflow), 32'd1);
      checkOutput("credit_after_3", 32'(credit), 32'd5);
      applyStimulus(0, '0, 0, 0, 1);
      idleCycles(10);
      @(negedge clock);
      checkOutput("two_writes_after_release", 32'(wr_count - base), 32'd2);
      checkOutput("drained_level", 32'(queue_level), 32'd0);

      // FCT and EOP in the same cycle
      applyStimulus(1, 9'h041, 0, 0, 1);
      idleCycles(3);
      applyStimulus(1, 9'h042, 0, 0, 1);
      idleCycles(3);
      @(negedge clock);
      checkOutput("credit_three", 32'(credit), 32'd3);
      applyStimulus(1, 9'h100, 1, 0, 1);
      @(negedge clock);
      checkOutput("credit_fct_plus_char", 32'(credit), 32'd10);
      idleCycles(6);
      @(negedge clock);
      checkOutput("eop_data", 32'(bus.fifo_data), 32'h100);

      // link_run drop mid-burst
      applyStimulus(1, 9'h051, 0, 1, 1);
      applyStimulus(1, 9'h052, 0, 1, 1);
      @(negedge clock);
      checkOutput("burst_level", 32'(queue_level), 32'd2);
      applyStimulus(0, '0, 0, 0, 1);
      applyStimulus(0, '0, 0, 0, 0);
      @(negedge clock);
      checkOutput("flush_level", 32'(queue_level), 32'd0);
      checkOutput("flush_credit", 32'(credit), 32'd0);
      checkOutput("flush_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      base = wr_count;
      applyStimulus(0, '0, 0, 0, 1);
      idleCycles(10);
      @(negedge clock);
      checkOutput("no_write_after_flush", 32'(wr_count - base), 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 99) < 40,
                       9'($urandom_range(0, 511)),
                       $urandom_range(0, 99) < 12,
                       $urandom_range(0, 99) < 30,
                       $urandom_range(0, 99) >= 2);
      end
      idleCycles(4);
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
